branch_predictor: RTL

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor.sv | 105 ++++++++++
 1 files changed

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Latency: predict is combinational; redirect and counters are registered (1 cycle).
// Backpressure: none; one resolve accepted every cycle, predict never stalls.
module branch_predictor #(
  parameter int ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pred_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        res_valid,
  input  logic [31:0] res_pc,
  input  logic        res_taken,
  input  logic [31:0] res_target,
  input  logic        res_pred_taken,
  input  logic [31:0] res_pred_target,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [31:0] branch_cnt,
  output logic [31:0] mispred_cnt
);

  localparam int IW = $clog2(ENTRIES);
  localparam int TW = 30 - IW;

  logic          valid_q  [ENTRIES];
  logic [TW-1:0] tag_q    [ENTRIES];
  logic [31:0]   target_q [ENTRIES];
  logic [1:0]    ctr_q    [ENTRIES];

  logic [IW-1:0] pidx, ridx;
  logic [TW-1:0] ptag, rtag;
  logic          phit, rhit, mispredict;
  logic          unused_pc_bits;

  // Word-aligned PCs: the low two bits never select anything.
  assign unused_pc_bits = ^{pred_pc[1:0], res_pc[1:0]};

  // Predict lookup reads the registered table, so same-cycle updates are not visible.
  always_comb begin
    pidx        = pred_pc[IW+1:2];
    ptag        = pred_pc[31:IW+2];
    phit        = valid_q[pidx] && (tag_q[pidx] == ptag);
    pred_taken  = phit && ctr_q[pidx][1];
    pred_target = pred_taken ? target_q[pidx] : pred_pc + 32'd4;
  end

  // Resolve-side lookup and mispredict detection.
  always_comb begin
    ridx       = res_pc[IW+1:2];
    rtag       = res_pc[31:IW+2];
    rhit       = valid_q[ridx] && (tag_q[ridx] == rtag);
    mispredict = res_valid &&
                 ((res_taken != res_pred_taken) ||
                  (res_taken && res_pred_taken && (res_target != res_pred_target)));
  end

  // Table update: train counters on hits, allocate only on taken misses.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'b01;
      end
    end else if (res_valid) begin
      if (rhit) begin
        if (res_taken) begin
          if (ctr_q[ridx] != 2'b11) ctr_q[ridx] <= ctr_q[ridx] + 2'd1;
          target_q[ridx] <= res_target;
        end else begin
          if (ctr_q[ridx] != 2'b00) ctr_q[ridx] <= ctr_q[ridx] - 2'd1;
        end
      end else if (res_taken) begin
        valid_q[ridx]  <= 1'b1;
        tag_q[ridx]    <= rtag;
        target_q[ridx] <= res_target;
        ctr_q[ridx]    <= 2'b10;
      end
    end
  end

  // Redirect pulse one cycle after a mispredicting resolve; pc holds otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= 32'h0;
    end else begin
      redirect_valid <= mispredict;
      if (mispredict) redirect_pc <= res_taken ? res_target : res_pc + 32'd4;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt  <= 32'h0;
      mispred_cnt <= 32'h0;
    end else begin
      if (res_valid && (branch_cnt != 32'hFFFF_FFFF)) branch_cnt <= branch_cnt + 32'd1;
      if (mispredict && (mispred_cnt != 32'hFFFF_FFFF)) mispred_cnt <= mispred_cnt + 32'd1;
    end
  end

endmodule
